seq_detector_param: RTL and testbench

Parametrised serial bit-pattern detector. It generalises the fixed 3-bit "101" Moore detector to a run-time programmable pattern of PAT_LEN bits, with a valid qualifier, selectable overlapping or non-overlapping matching, and a saturating match counter. It sits on a 1-bit serial stream after the input synchroniser and drives a Moore match flag plus a count readable by control logic.

---
 rtl/seq_detector_param.sv | 83 ++++++++
 tb/tb_seq_detector_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: PAT_LEN-bit run-time pattern, valid-qualified
// input, overlapping or non-overlapping matching, registered Moore flag and saturating count.
module seq_detector_param #(
  parameter int                 PAT_LEN   = 3,
  parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(3'b101),
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] hist;
  logic [FW-1:0]      fill;

  logic [PAT_LEN-1:0] hist_next;
  logic [FW-1:0]      fill_next;
  logic               accept;
  logic               match;
  logic [CNT_W-1:0]   cnt_next;

  // Newest bit enters at the LSB, so the oldest bit lines up with pat's MSB.
  generate
    if (PAT_LEN == 1) begin : g_one
      assign hist_next = in;
    end else begin : g_multi
      assign hist_next = {hist[PAT_LEN-2:0], in};
    end
  endgenerate

  assign accept    = in_valid && !cfg_load;
  assign fill_next = (fill == FULL) ? FULL : fill + FW'(1);
  assign match     = accept && (hist_next == pat) && (fill_next == FULL);

  // Clear beats a same-cycle match; otherwise count up and stick at all-ones.
  always_comb begin
    cnt_next = match_count;
    if (cnt_clear) begin
      cnt_next = '0;
    end else if (match && (match_count != CNT_MAX)) begin
      cnt_next = match_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat         <= PAT_RESET;
      hist        <= '0;
      fill        <= '0;
      out         <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      match_count <= cnt_next;
      cnt_sat     <= (cnt_next == CNT_MAX);
      if (cfg_load) begin
        pat  <= cfg_pattern;
        hist <= '0;
        fill <= '0;
        out  <= 1'b0;
      end else if (in_valid) begin
        // Non-overlap mode restarts the fill so the next match needs PAT_LEN fresh bits.
        hist <= hist_next;
        fill <= (match && !cfg_overlap) ? '0 : fill_next;
        out  <= match;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance (CNT_W=8) and a
// CNT_W=2 instance share one stimulus stream.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in;
  logic       cfg_load;
  logic [2:0] cfg_pattern;
  logic       cfg_overlap;
  logic       cnt_clear;

  logic       out_a;
  logic [7:0] count_a;
  logic       sat_a;
  logic       out_b;
  logic [1:0] count_b;
  logic       sat_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(3), .PAT_RESET(3'b101), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clear(cnt_clear), .out(out_a), .match_count(count_a), .cnt_sat(sat_a)
  );

  seq_detector_param #(.PAT_LEN(3), .PAT_RESET(3'b101), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cnt_clear(cnt_clear), .out(out_b), .match_count(count_b), .cnt_sat(sat_b)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic       din;
    logic       ovl;
    logic       ld;
    logic [2:0] pat;
    logic       clr;
    logic       exp_out;
    logic [7:0] exp_cnt;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[$];

  // Drive one cycle of inputs, then return 1 time unit after the active edge.
  task automatic applyStimulus(input logic r, input logic v, input logic d, input logic o,
                               input logic l, input logic [2:0] p, input logic c);
    reset       = r;
    in_valid    = v;
    in          = d;
    cfg_overlap = o;
    cfg_load    = l;
    cfg_pattern = p;
    cnt_clear   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic use_b, input logic exp_out,
                             input logic [7:0] exp_cnt, input logic exp_sat);
    logic       act_out;
    logic [7:0] act_cnt;
    logic       act_sat;
    act_out = use_b ? out_b : out_a;
    act_cnt = use_b ? {6'b0, count_b} : count_a;
    act_sat = use_b ? sat_b : sat_a;
    checks++;
    if (act_out !== exp_out || act_cnt !== exp_cnt || act_sat !== exp_sat) begin
      failures++;
      $display("[TB] FAIL %s: out/count/sat got %0b/%0d/%0b expected %0b/%0d/%0b",
               name, act_out, act_cnt, act_sat, exp_out, exp_cnt, exp_sat);
    end
  endtask

  task automatic sendBit(input logic d, input logic o, input logic c);
    applyStimulus(1'b0, 1'b1, d, o, 1'b0, 3'b000, c);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 3'b000; cfg_overlap = 1'b1; cnt_clear = 1'b0;

    // Overlapping stream 1,0,1,0,1 then non-overlapping 1,0,1,0,1,1,0,1.
    //                 rst  vld  din  ovl  ld   pat     clr  out  cnt  sat
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,1'b0,1'b1,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,1'b0,1'b0,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b1,1'b0,3'b000,1'b0,1'b1,8'd2,1'b0});
    vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,8'd0,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b1,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b0,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b0,1'b0,3'b000,1'b0,1'b0,8'd1,1'b0});
    vecs.push_back(vec_t'{1'b0,1'b1,1'b1,1'b0,1'b0,3'b000,1'b0,1'b1,8'd2,1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].din, vecs[i].ovl,
                    vecs[i].ld, vecs[i].pat, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].exp_out, vecs[i].exp_cnt, vecs[i].exp_sat);
    end

    // Stall: the flag holds across invalid cycles and drops on the next accepted bit.
    doReset();
    sendBit(1'b1, 1'b1, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("stall_match", 1'b0, 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, ~in, 1'b1, 1'b0, 3'b000, 1'b0);
      checkOutput($sformatf("stall_hold%0d", i), 1'b0, 1'b1, 8'd1, 1'b0);
    end
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("stall_release", 1'b0, 1'b0, 8'd1, 1'b0);

    // Saturation on the 2-bit counter, then clear colliding with a match.
    doReset();
    for (int i = 0; i < 9; i++) begin
      logic       d;
      logic [1:0] ec;
      d  = (i % 2 == 0);
      ec = (i < 2) ? 2'd0 : (i < 4) ? 2'd1 : (i < 6) ? 2'd2 : 2'd3;
      sendBit(d, 1'b1, 1'b0);
      checkOutput($sformatf("sat_bit%0d", i), 1'b1, (i >= 2) && d, {6'b0, ec}, (i >= 6));
    end
    checkOutput("nosat_wide", 1'b0, 1'b1, 8'd4, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    checkOutput("sat_hold", 1'b1, 1'b0, 8'd3, 1'b1);
    sendBit(1'b1, 1'b1, 1'b1);
    checkOutput("clear_vs_match", 1'b1, 1'b1, 8'd0, 1'b0);

    // Pattern load discards the coincident bit and restarts detection.
    doReset();
    sendBit(1'b1, 1'b1, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0);
    checkOutput("load", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("load_b1", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("load_b2", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    checkOutput("load_match", 1'b0, 1'b1, 8'd1, 1'b0);

    // Reset mid-pattern restores 101 and wins over a valid bit.
    sendBit(1'b1, 1'b1, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    checkOutput("reset_mid", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("reset_fill1", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    checkOutput("reset_fill2", 1'b0, 1'b0, 8'd0, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    checkOutput("reset_pat101", 1'b0, 1'b1, 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
